// File: rtl/pwm_tone_generator_pkg.sv
// Shared constants for the PWM tone generator: waveform select codes and
// the carrier top loaded out of reset.
package pwm_tone_generator_pkg;

  typedef enum logic [1:0] {
    WAVE_SQUARE = 2'd0,
    WAVE_SAW    = 2'd1,
    WAVE_TRI    = 2'd2,
    WAVE_OFF    = 2'd3
  } wave_sel_e;

  localparam logic [7:0] DEFAULT_TOP = 8'hFF;

endpackage

// File: rtl/pwm_phase_accumulator.sv
// Phase accumulator plus waveform shaping; produces the 8-bit sample that the
// carrier logic latches at each period boundary.
module pwm_phase_accumulator
  import pwm_tone_generator_pkg::*;
#(
  parameter int PHASE_WIDTH = 32
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic [PHASE_WIDTH-1:0] i_phase_delta,
  input  logic [1:0]             i_wave_sel,
  output logic [7:0]             o_wave
);

  logic [PHASE_WIDTH-1:0] phase_q;
  logic [PHASE_WIDTH-1:0] phase_d;
  logic                   rest;
  logic [8:0]             p;

  // A zero increment parks the phase at 0 so the next note starts cleanly.
  assign rest    = (i_phase_delta == '0);
  assign phase_d = rest ? '0 : phase_q + i_phase_delta;
  assign p       = phase_q[PHASE_WIDTH-1 -: 9];

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      phase_q <= '0;
    end else begin
      phase_q <= phase_d;
    end
  end

  always_comb begin
    o_wave = 8'h00;
    if (!rest) begin
      case (i_wave_sel)
        WAVE_SQUARE: o_wave = p[8] ? 8'hFF : 8'h00;
        WAVE_SAW:    o_wave = p[8:1];
        WAVE_TRI:    o_wave = p[8] ? ~p[7:0] : p[7:0];
        default:     o_wave = 8'h00;
      endcase
    end
  end

endmodule

// File: rtl/pwm_tone_generator.sv
// Audio output stage: carrier counter with shadowed top, sample/compare
// latching at carrier boundaries, and the registered PWM output.
module pwm_tone_generator
  import pwm_tone_generator_pkg::*;
#(
  parameter int PHASE_WIDTH = 32,
  parameter int TOP_WIDTH   = 8
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic [TOP_WIDTH-1:0]   i_top,
  input  logic                   i_top_valid,
  input  logic [PHASE_WIDTH-1:0] i_phase_delta,
  input  logic [1:0]             i_wave_sel,
  output logic                   o_pwm,
  output logic [7:0]             o_sample,
  output logic                   o_period_start
);

  logic [TOP_WIDTH-1:0] count_q, count_d;
  logic [TOP_WIDTH-1:0] top_q, top_pend_q, new_top;
  logic                 pend_q;
  logic [TOP_WIDTH-1:0] compare_q, compare_d;
  logic [7:0]           sample_q;
  logic                 pwm_q;
  logic                 period_start_q;
  logic                 boundary;
  logic [7:0]           wave;
  logic [TOP_WIDTH:0]   top_plus1;
  logic [TOP_WIDTH+7:0] product;

  pwm_phase_accumulator #(
    .PHASE_WIDTH(PHASE_WIDTH)
  ) u_phase (
    .i_clk         (i_clk),
    .i_reset       (i_reset),
    .i_phase_delta (i_phase_delta),
    .i_wave_sel    (i_wave_sel),
    .o_wave        (wave)
  );

  assign boundary = (count_q == top_q);
  assign count_d  = boundary ? '0 : count_q + 1'b1;

  // A top arriving in the boundary cycle itself beats the pending shadow value.
  assign new_top = i_top_valid ? i_top : (pend_q ? top_pend_q : top_q);

  // w*(top+1) always fits in TOP_WIDTH+8 bits and the quotient stays <= top.
  assign top_plus1 = {1'b0, new_top} + (TOP_WIDTH + 1)'(1);
  assign product   = (TOP_WIDTH + 8)'(wave) * (TOP_WIDTH + 8)'(top_plus1);
  assign compare_d = TOP_WIDTH'(product >> 8);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      count_q        <= '0;
      top_q          <= TOP_WIDTH'(DEFAULT_TOP);
      top_pend_q     <= TOP_WIDTH'(DEFAULT_TOP);
      pend_q         <= 1'b0;
      compare_q      <= '0;
      sample_q       <= 8'h00;
      pwm_q          <= 1'b0;
      period_start_q <= 1'b0;
    end else begin
      count_q        <= count_d;
      pwm_q          <= (count_q < compare_q);
      period_start_q <= boundary;
      if (i_top_valid) begin
        top_pend_q <= i_top;
      end
      if (boundary) begin
        top_q     <= new_top;
        pend_q    <= 1'b0;
        sample_q  <= wave;
        compare_q <= compare_d;
      end else if (i_top_valid) begin
        pend_q <= 1'b1;
      end
    end
  end

  assign o_pwm          = pwm_q;
  assign o_sample       = sample_q;
  assign o_period_start = period_start_q;

endmodule

// File: tb/tb_pwm_tone_generator.sv
// Directed bench for pwm_tone_generator with a period-level reference model
// checked every clock, plus hand-computed literal expectations.
module tb_pwm_tone_generator;
  import pwm_tone_generator_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  top = 8'd0;
  logic        valid = 1'b0;
  logic [31:0] delta = 32'd0;
  logic [1:0]  sel = 2'd0;
  logic        pwm;
  logic [7:0]  sample;
  logic        ps;

  int total = 0;
  int bad = 0;

  // Model state: position in the current carrier period, the top governing it,
  // the shadow value, the latched sample and the number of high clocks it earns.
  int              m_pos = 0;
  int              m_top = 255;
  bit              m_pend = 1'b0;
  int              m_pv = 255;
  int              m_sample = 0;
  int              m_hi = 0;
  bit              m_ps = 1'b0;
  longint unsigned m_phase = 0;

  pwm_tone_generator #(.PHASE_WIDTH(32), .TOP_WIDTH(8)) dut (
    .i_clk          (clk),
    .i_reset        (reset),
    .i_top          (top),
    .i_top_valid    (valid),
    .i_phase_delta  (delta),
    .i_wave_sel     (sel),
    .o_pwm          (pwm),
    .o_sample       (sample),
    .o_period_start (ps)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int wave_of(input longint unsigned ph, input logic [1:0] s,
                                 input logic [31:0] d);
    int p;
    if (d == 32'd0) return 0;
    p = int'(ph >> 23);
    case (s)
      2'd0:    return (p >= 256) ? 255 : 0;
      2'd1:    return p / 2;
      2'd2:    return (p >= 256) ? 511 - p : p;
      default: return 0;
    endcase
  endfunction

  task automatic model_step();
    int w;
    int nt;
    bit bnd;
    if (reset) begin
      m_pos = 0; m_top = 255; m_pend = 1'b0; m_pv = 255;
      m_sample = 0; m_hi = 0; m_ps = 1'b0; m_phase = 0;
      return;
    end
    w   = wave_of(m_phase, sel, delta);
    bnd = (m_pos == m_top);
    if (bnd) begin
      nt = valid ? int'(top) : (m_pend ? m_pv : m_top);
      m_top    = nt;
      m_pend   = 1'b0;
      m_sample = w;
      m_hi     = (w * (nt + 1)) / 256;
      m_pos    = 0;
      m_ps     = 1'b1;
    end else begin
      m_pos++;
      m_ps = 1'b0;
    end
    if (valid) begin
      m_pv = int'(top);
      if (!bnd) m_pend = 1'b1;
    end
    m_phase = (delta == 32'd0) ? 0 : (m_phase + delta) % 64'h1_0000_0000;
  endtask

  // Per-cycle compare: pwm is high for positions 1..hi of each period
  // (one-clock lag behind the counter), never at position 0.
  initial begin
    forever begin
      @(posedge clk);
      model_step();
      #1;
      check("model_sample", int'(sample), m_sample);
      check("model_pwm", int'(pwm), (m_pos >= 1 && m_pos <= m_hi) ? 1 : 0);
      check("model_period_start", int'(ps), int'(m_ps));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ps(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!ps && n < 2000);
  endtask

  task automatic measure(input int len, output int hi);
    hi = int'(pwm);
    repeat (len - 1) begin
      tick();
      hi += int'(pwm);
    end
  endtask

  initial begin
    int n;
    int hi;
    int ff_periods;

    // Reset and first boundary.
    repeat (5) tick();
    check("reset_pwm", int'(pwm), 0);
    check("reset_sample", int'(sample), 0);
    check("reset_period_start", int'(ps), 0);
    reset = 1'b0;
    wait_ps(n);
    check("first_period_start", n, 256);
    wait_ps(n);
    check("reset_spacing", n, 256);

    // Square wave: first 129 periods latch 0, then 128 periods latch FF.
    delta = 32'h0001_0000;
    sel   = WAVE_SQUARE;
    ff_periods = 0;
    for (int k = 0; k < 257; k++) begin
      check("square_sample", int'(sample), (k >= 129) ? 255 : 0);
      if (sample == 8'hFF) ff_periods++;
      measure(256, hi);
      check("square_high_clocks", hi, (k >= 129) ? 255 : 0);
      wait_ps(n);
      check("square_spacing", n, 1);
    end
    check("square_ff_run", ff_periods, 128);
    delta = 32'd0;

    // Shadowed top change mid-period.
    repeat (10) tick();
    top = 8'd99; valid = 1'b1;
    tick();
    valid = 1'b0;
    wait_ps(n);
    check("shadow_current_period", n + 11, 256);
    wait_ps(n);
    check("shadow_new_spacing_a", n, 100);
    wait_ps(n);
    check("shadow_new_spacing_b", n, 100);

    // Top presented in the boundary cycle overrides the pending value.
    repeat (10) tick();
    top = 8'd99; valid = 1'b1;
    tick();
    valid = 1'b0;
    repeat (88) tick();
    top = 8'd49; valid = 1'b1;
    tick();
    valid = 1'b0;
    check("boundary_load_ps", int'(ps), 1);
    wait_ps(n);
    check("boundary_load_spacing_a", n, 50);
    wait_ps(n);
    check("boundary_load_spacing_b", n, 50);

    // Saw at w=128 with top=99, then rest.
    sel = WAVE_SAW;
    repeat (5) tick();
    top = 8'd99; valid = 1'b1;
    tick();
    valid = 1'b0;
    wait_ps(n);
    check("saw_top_switch", n, 44);
    delta = 32'h8000_0000;
    tick();
    delta = 32'd1;
    wait_ps(n);
    check("saw_sample", int'(sample), 128);
    measure(100, hi);
    check("saw_high_clocks", hi, 50);
    wait_ps(n);
    delta = 32'd0;
    measure(100, hi);
    check("rest_current_period", hi, 50);
    wait_ps(n);
    check("rest_sample", int'(sample), 0);
    measure(100, hi);
    check("rest_high_clocks", hi, 0);
    wait_ps(n);

    // Asynchronous reset mid-period with top=7 and w=128 (compare 4).
    delta = 32'h8000_0000;
    tick();
    delta = 32'd1;
    top = 8'd7; valid = 1'b1;
    tick();
    valid = 1'b0;
    wait_ps(n);
    check("top7_switch", n, 98);
    check("top7_sample", int'(sample), 128);
    repeat (4) tick();
    check("top7_pwm_at_count4", int'(pwm), 1);
    #2;
    reset = 1'b1;
    #1;
    check("async_pwm", int'(pwm), 0);
    check("async_sample", int'(sample), 0);
    check("async_period_start", int'(ps), 0);
    tick();
    tick();
    reset = 1'b0;
    wait_ps(n);
    check("post_reset_period", n, 256);

    // top=0: boundary every clock, period_start held, pwm never high.
    top = 8'd0; valid = 1'b1;
    tick();
    valid = 1'b0;
    sel = WAVE_SQUARE;
    delta = 32'h8000_0000;
    wait_ps(n);
    check("top0_switch", n, 255);
    for (int i = 0; i < 8; i++) begin
      tick();
      check("top0_period_start", int'(ps), 1);
      check("top0_pwm", int'(pwm), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule
